shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter COUNT_BITS, default 5: width of the shift count; count = B[COUNT_BITS-1:0], range 0-31.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1: request present.
REQ-006 Port in_ready, output, 1: block can accept a request.
REQ-007 Port alu_op, input, 5: ROL=6, ROR=7, ROLC=8, RORC=9, SHL=10, SHR=11, SHRA=12, SHLA=13.
REQ-008 Port size, input, 1: 0 = byte (bits 7:0), 1 = word.
REQ-009 Port A, input, 16: operand.
REQ-010 Port B, input, 16: count source.
REQ-011 Port flags_in, input, 6: current flags; bit 0 AC, 1 CY, 2 V, 3 P, 4 S, 5 Z.
REQ-012 Port flush, input, 1: synchronous abort.
REQ-013 Port out_valid, output, 1: one-cycle result strobe.
REQ-014 Port R, output, 16: result.
REQ-015 Port flags, output, 6: updated flags, same bit order as flags_in.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and DONE; in_ready = (state == IDLE).
REQ-017 On a rising edge with in_valid && in_ready, the block SHALL latch op, size, A, flags_in and count; it then enters SHIFT if count > 0, else DONE.
REQ-018 SHIFT SHALL perform exactly one 1-bit step per clock and decrement the remaining count; after the final step it SHALL enter DONE.
REQ-019 out_valid SHALL be high only in DONE, for exactly one clock; DONE SHALL always return to IDLE.
REQ-020 For count n, out_valid SHALL first be sampled high at the (n+1)-th rising edge after the accepting edge; throughput SHALL be one request per n+2 clocks.
REQ-021 R and flags SHALL hold their last values until the next accepted request completes.
REQ-022 In byte mode, steps SHALL act on bits 7:0 with msb = bit 7; R[15:8] SHALL equal A[15:8].
REQ-023 Step rules:
- ROL: CY=msb, lsb=old msb.
- ROR: CY=lsb, msb=old lsb.
- ROLC: lsb=CY, CY=old msb.
- RORC: msb=CY, CY=old lsb.
- SHL and SHLA: CY=msb, lsb=0.
- SHR: CY=lsb, msb=0.
- SHRA: CY=lsb, msb kept.
REQ-024 V SHALL be computed from the final result as follows:
- ROL, ROLC, SHL, SHLA: V = msb XOR CY.
- ROR, RORC, SHR: V = msb XOR (msb-1).
- SHRA: V = 0.
REQ-025 For shifts with n ≥ 1: S = result msb; Z = (sized result == 0); P = even parity of R[7:0]. For rotates, S, Z and P SHALL pass through from flags_in. AC SHALL always pass through.
REQ-026 For count 0, R SHALL equal A and flags SHALL equal flags_in.
REQ-027 An unsupported alu_op SHALL be accepted and treated as count 0.
REQ-028 flush SHALL force IDLE at the next edge from any state, with no out_valid and R/flags unchanged; flush coincident with in_valid in IDLE SHALL drop the request.
REQ-029 Inputs SHALL be ignored while in_ready is low.

Reset
REQ-030 While reset_n is low, regardless of clk: state = IDLE, out_valid = 0, R = 16'h0000, flags = 6'b000000, in_ready = 1.
REQ-031 Reset asserted mid-operation SHALL abandon the request with no out_valid; operation SHALL resume at the first edge after reset_n rises.

Verification
REQ-032 Byte SHR, A=16'h1281, B=1, flags_in=0 -> out_valid at edge 2; R=16'h1240; CY=1, V=1, S=0, Z=0, P=0.
REQ-033 Word ROLC, A=16'h8000, B=2, CY_in=0, Z_in=1 -> out_valid at edge 3; R=16'h0001; CY=0, V=0, Z=1 (unchanged).
REQ-034 Byte SHRA, A=16'h0080, B=3 -> out_valid at edge 4; R=16'h00F0; CY=0, S=1, Z=0, P=1, V=0.
REQ-035 Word SHL, A=16'h1234, B=16'h0020 (masked count 0), flags_in=6'b101010 -> out_valid at edge 1; R=16'h1234; flags=6'b101010.
REQ-036 Word SHL, B=20, flush at edge 5 -> no out_valid; in_ready=1 after edge 5; R and flags unchanged.
REQ-037 Word ROR, B=10, reset_n pulsed low at cycle 4 -> outputs at reset values immediately; a new request completes normally after release.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle rotate/shift unit, one bit position per clock.
// A request is latched in IDLE, stepped in SHIFT, and its result is published
// to R/flags on the transition into DONE, where out_valid strobes for one cycle.
module shift_sequencer #(
  parameter int COUNT_BITS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  alu_op,
  input  logic        size,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [5:0]  flags_in,
  input  logic        flush,
  output logic        out_valid,
  output logic [15:0] R,
  output logic [5:0]  flags
);

  localparam logic [4:0] OP_ROL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROLC = 5'd8;
  localparam logic [4:0] OP_RORC = 5'd9;
  localparam logic [4:0] OP_SHL  = 5'd10;
  localparam logic [4:0] OP_SHR  = 5'd11;
  localparam logic [4:0] OP_SHRA = 5'd12;
  localparam logic [4:0] OP_SHLA = 5'd13;

  // flag bit positions
  localparam int F_AC = 0;
  localparam int F_CY = 1;
  localparam int F_V  = 2;
  localparam int F_P  = 3;
  localparam int F_S  = 4;
  localparam int F_Z  = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Latched request; only the flag bits that pass through are kept, CY lives
  // in the working carry register.
  typedef struct packed {
    logic [4:0] op;
    logic       size;
    logic       ac;
    logic       p;
    logic       s;
    logic       z;
  } req_t;

  state_t                r_state, w_next;
  req_t                  r_req;
  logic [15:0]           r_work;
  logic                  r_cy;
  logic [COUNT_BITS-1:0] r_cnt;
  logic [15:0]           r_R;
  logic [5:0]            r_flags;

  logic                  w_op_ok;
  logic [COUNT_BITS-1:0] w_cnt_in;
  logic                  w_last;
  logic                  w_msb;
  logic                  w_lsb;
  logic                  w_left;
  logic                  w_in_bit;
  logic                  w_step_cy;
  logic [15:0]           w_step_val;
  logic [5:0]            w_res_flags;
  logic                  w_unused_b;

  // Upper count-source bits are deliberately ignored (count is masked).
  assign w_unused_b = ^B[15:COUNT_BITS];

  // Unsupported opcodes complete like a zero-count request.
  assign w_op_ok  = (alu_op >= OP_ROL) && (alu_op <= OP_SHLA);
  assign w_cnt_in = w_op_ok ? B[COUNT_BITS-1:0] : '0;
  assign w_last   = (r_cnt == COUNT_BITS'(1));

  assign R     = r_R;
  assign flags = r_flags;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and handshake outputs; flush wins over everything
  always_comb begin
    w_next    = r_state;
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) w_next = (w_cnt_in != '0) ? S_SHIFT : S_DONE;
        S_SHIFT: if (w_last)   w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // One-bit step: pick direction, incoming bit and new carry per opcode
  always_comb begin
    w_msb     = r_req.size ? r_work[15] : r_work[7];
    w_lsb     = r_work[0];
    w_left    = 1'b1;
    w_in_bit  = 1'b0;
    w_step_cy = r_cy;
    case (r_req.op)
      OP_ROL:  begin w_left = 1'b1; w_in_bit = w_msb; w_step_cy = w_msb; end
      OP_ROR:  begin w_left = 1'b0; w_in_bit = w_lsb; w_step_cy = w_lsb; end
      OP_ROLC: begin w_left = 1'b1; w_in_bit = r_cy;  w_step_cy = w_msb; end
      OP_RORC: begin w_left = 1'b0; w_in_bit = r_cy;  w_step_cy = w_lsb; end
      OP_SHL,
      OP_SHLA: begin w_left = 1'b1; w_in_bit = 1'b0;  w_step_cy = w_msb; end
      OP_SHR:  begin w_left = 1'b0; w_in_bit = 1'b0;  w_step_cy = w_lsb; end
      OP_SHRA: begin w_left = 1'b0; w_in_bit = w_msb; w_step_cy = w_lsb; end
      default: begin w_left = 1'b1; w_in_bit = 1'b0;  w_step_cy = r_cy;  end
    endcase
    // byte mode leaves the upper byte untouched
    if (w_left) begin
      w_step_val = r_req.size ? {r_work[14:0], w_in_bit}
                              : {r_work[15:8], r_work[6:0], w_in_bit};
    end else begin
      w_step_val = r_req.size ? {w_in_bit, r_work[15:1]}
                              : {r_work[15:8], w_in_bit, r_work[7:1]};
    end
  end

  // Result flags derived from the value produced by the final step
  always_comb begin
    logic msb, msb1, zero, par, is_shift;
    msb      = r_req.size ? w_step_val[15] : w_step_val[7];
    msb1     = r_req.size ? w_step_val[14] : w_step_val[6];
    zero     = r_req.size ? (w_step_val == 16'h0000) : (w_step_val[7:0] == 8'h00);
    par      = ~^w_step_val[7:0];
    is_shift = (r_req.op == OP_SHL) || (r_req.op == OP_SHR) ||
               (r_req.op == OP_SHRA) || (r_req.op == OP_SHLA);
    w_res_flags       = '0;
    w_res_flags[F_AC] = r_req.ac;
    w_res_flags[F_CY] = w_step_cy;
    case (r_req.op)
      OP_ROL, OP_ROLC, OP_SHL, OP_SHLA: w_res_flags[F_V] = msb ^ w_step_cy;
      OP_ROR, OP_RORC, OP_SHR:          w_res_flags[F_V] = msb ^ msb1;
      default:                          w_res_flags[F_V] = 1'b0;
    endcase
    if (is_shift) begin
      w_res_flags[F_S] = msb;
      w_res_flags[F_Z] = zero;
      w_res_flags[F_P] = par;
    end else begin
      w_res_flags[F_S] = r_req.s;
      w_res_flags[F_Z] = r_req.z;
      w_res_flags[F_P] = r_req.p;
    end
  end

  // Datapath: latch on accept, step in SHIFT, publish result entering DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req   <= '0;
      r_work  <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      r_R     <= '0;
      r_flags <= '0;
    end else if (!flush) begin
      if (r_state == S_IDLE && in_valid) begin
        r_req  <= '{op: alu_op, size: size, ac: flags_in[F_AC], p: flags_in[F_P],
                    s: flags_in[F_S], z: flags_in[F_Z]};
        r_work <= A;
        r_cy   <= flags_in[F_CY];
        r_cnt  <= w_cnt_in;
        if (w_cnt_in == '0) begin
          r_R     <= A;
          r_flags <= flags_in;
        end
      end else if (r_state == S_SHIFT) begin
        r_work <= w_step_val;
        r_cy   <= w_step_cy;
        r_cnt  <= r_cnt - COUNT_BITS'(1);
        if (w_last) begin
          r_R     <= w_step_val;
          r_flags <= w_res_flags;
        end
      end
    end
  end

endmodule
